// File: rtl/pipe_ctrl.sv
// Issue/hazard controller for an in-order pipeline.
// Tracks in-flight register writes with one small counter per architectural
// register, holds decode on RAW or counter-saturation hazards, and squashes
// fetch/decode for a fixed number of cycles after a taken branch.
module pipe_ctrl #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       issue_valid_i,
    input  logic [4:0] issue_rs1_i,
    input  logic [4:0] issue_rs2_i,
    input  logic [4:0] issue_rd_i,
    input  logic       issue_we_i,
    input  logic       exe_busy_i,
    input  logic       branch_taken_i,
    input  logic       wb_valid_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    output logic       issue_ready_o,
    output logic       stall_o,
    output logic       flush_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [3:0]       FlushLoad = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             raw_hazard, sat_hazard, in_run;
    logic             issue_fire, wb_fire;

    // Counter lookups; x0 (and any address beyond NUM_REGS) reads as zero.
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        cnt_wb  = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (issue_rs1_i == 5'(i)) cnt_rs1 = cnt_q[i];
            if (issue_rs2_i == 5'(i)) cnt_rs2 = cnt_q[i];
            if (issue_rd_i  == 5'(i)) cnt_rd  = cnt_q[i];
            if (wb_rd_i     == 5'(i)) cnt_wb  = cnt_q[i];
        end
    end

    // Hazard detection and issue handshake; everything held low during reset.
    always_comb begin
        in_run        = (state_q == StRun);
        raw_hazard    = (cnt_rs1 != '0) || (cnt_rs2 != '0);
        sat_hazard    = issue_we_i && (cnt_rd == CntMax);
        issue_ready_o = rstn_i && !raw_hazard && !sat_hazard && !exe_busy_i &&
                        in_run && !branch_taken_i;
        stall_o       = rstn_i && issue_valid_i && !issue_ready_o && in_run &&
                        !branch_taken_i;
        issue_fire    = issue_valid_i && issue_ready_o && issue_we_i;
        wb_fire       = wb_valid_i && wb_we_i;
    end

    // In-flight counter update; simultaneous issue and writeback cancel out.
    always_comb begin
        busy_d   = 1'b0;
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue_fire && (issue_rd_i == 5'(i)) &&
                !(wb_fire && (wb_rd_i == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (wb_fire && (wb_rd_i == 5'(i)) &&
                         !(issue_fire && (issue_rd_i == 5'(i))) &&
                         (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    // Flush sequencer: a branch (re)loads the down-counter, zero ends the flush.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (branch_taken_i) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end
            end
            StFlush: begin
                if (branch_taken_i) begin
                    flush_cnt_d = FlushLoad;
                end else if (flush_cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StRun;
            flush_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A writeback with nothing in flight means upstream bookkeeping is broken.
    always_ff @(posedge clk_i) begin
        if (rstn_i && wb_fire && (wb_rd_i != 5'd0)) begin
            assert (cnt_wb != '0) else $error("pipe_ctrl: writeback underflow on x%0d", wb_rd_i);
        end
    end

    assign flush_o = (state_q == StFlush);
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// cycles compared against a reference model of in-flight writes per register.
module tb_pipe_ctrl;

    localparam int NR   = 32;
    localparam int CW   = 2;
    localparam int FC   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       issue_valid, issue_we, exe_busy, branch;
    logic [4:0] rs1, rs2, rd;
    logic       wb_valid, wb_we;
    logic [4:0] wb_rd;
    logic       issue_ready, stall, flush, busy;

    pipe_ctrl #(
        .NUM_REGS    (NR),
        .CNT_W       (CW),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .issue_valid_i (issue_valid),
        .issue_rs1_i   (rs1),
        .issue_rs2_i   (rs2),
        .issue_rd_i    (rd),
        .issue_we_i    (issue_we),
        .exe_busy_i    (exe_busy),
        .branch_taken_i(branch),
        .wb_valid_i    (wb_valid),
        .wb_we_i       (wb_we),
        .wb_rd_i       (wb_rd),
        .issue_ready_o (issue_ready),
        .stall_o       (stall),
        .flush_o       (flush),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding writes per register, remaining flush cycles.
    int   m_cnt [NR];
    int   flush_rem = 0;
    logic m_busy = 1'b0;
    logic m_accept = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        flush_rem = 0;
        m_busy    = 1'b0;
    endfunction

    task automatic set_issue(input logic v, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic w);
        issue_valid = v; rs1 = a; rs2 = b; rd = d; issue_we = w;
    endtask

    task automatic set_wb(input logic v, input logic w, input logic [4:0] d);
        wb_valid = v; wb_we = w; wb_rd = d;
    endtask

    task automatic set_idle();
        set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(1'b0, 1'b0, 5'd0);
        exe_busy = 1'b0;
        branch   = 1'b0;
    endtask

    // Called at a falling edge after inputs are driven; compares all outputs.
    task automatic check_cycle(input string tag);
        logic raw, sat, in_run, e_ready, e_stall;
        if (!rstn) model_reset();
        #1;
        raw = (rs1 != 0 && m_cnt[rs1] != 0) || (rs2 != 0 && m_cnt[rs2] != 0);
        sat = issue_we && rd != 0 && m_cnt[rd] == CMAX;
        in_run  = (flush_rem == 0);
        e_ready = rstn && !raw && !sat && !exe_busy && in_run && !branch;
        e_stall = rstn && issue_valid && !e_ready && in_run && !branch;
        m_accept = issue_valid && e_ready;
        chk({tag, "/ready"}, issue_ready, e_ready);
        chk({tag, "/stall"}, stall, e_stall);
        chk({tag, "/flush"}, flush, flush_rem != 0);
        chk({tag, "/busy"}, busy, m_busy);
    endtask

    // Apply the rising edge to the model, then return to the next falling edge.
    task automatic advance();
        int inc_r, dec_r;
        @(posedge clk);
        if (rstn) begin
            inc_r = (m_accept && issue_we && rd != 0) ? int'(rd) : -1;
            dec_r = (wb_valid && wb_we && wb_rd != 0) ? int'(wb_rd) : -1;
            if (inc_r != dec_r) begin
                if (inc_r >= 0) m_cnt[inc_r]++;
                if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
            end
            if (branch) flush_rem = FC;
            else if (flush_rem > 0) flush_rem--;
            m_busy = 1'b0;
            for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) m_busy = 1'b1;
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        check_cycle(tag);
        advance();
    endtask

    initial begin
        int q[$];
        set_idle();
        rstn = 1'b0;
        @(negedge clk);

        // Reset: outputs low even with a valid request present.
        set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        check_cycle("rst");
        chk("rst/ready_low", issue_ready, 1'b0);
        advance();
        rstn = 1'b1;
        set_idle();
        step("idle");

        // RAW on x5 until its writeback, ready the cycle after.
        set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        check_cycle("w5");
        chk("w5/accept", issue_ready, 1'b1);
        advance();
        set_issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        check_cycle("r5a");
        chk("r5a/raw_stall", stall, 1'b1);
        advance();
        step("r5b");
        set_wb(1'b1, 1'b1, 5'd5);
        check_cycle("r5wb");
        chk("r5wb/busy_high", busy, 1'b1);
        advance();
        set_wb(1'b0, 1'b0, 5'd0);
        check_cycle("r5go");
        chk("r5go/ready", issue_ready, 1'b1);
        chk("r5go/busy_low", busy, 1'b0);
        advance();
        set_idle();

        // Saturation on x7.
        set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        step("w7a");
        step("w7b");
        step("w7c");
        check_cycle("w7d");
        chk("w7d/sat_stall", stall, 1'b1);
        advance();
        set_wb(1'b1, 1'b1, 5'd7);
        check_cycle("w7d_wb");
        chk("w7d_wb/sat_stall", stall, 1'b1);
        advance();
        set_wb(1'b0, 1'b0, 5'd0);
        check_cycle("w7d_go");
        chk("w7d_go/ready", issue_ready, 1'b1);
        advance();
        set_idle();
        set_wb(1'b1, 1'b1, 5'd7);
        step("d7a");
        step("d7b");
        step("d7c");
        set_idle();
        step("d7idle");

        // Simultaneous issue and writeback of x9 leave one write in flight.
        set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        step("w9");
        set_wb(1'b1, 1'b1, 5'd9);
        check_cycle("w9wb");
        chk("w9wb/ready", issue_ready, 1'b1);
        advance();
        set_idle();
        check_cycle("w9hold");
        chk("w9hold/busy", busy, 1'b1);
        advance();
        set_issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        set_wb(1'b1, 1'b1, 5'd9);
        step("w9drain");
        set_wb(1'b0, 1'b0, 5'd0);
        check_cycle("w9free");
        chk("w9free/ready", issue_ready, 1'b1);
        advance();
        set_idle();

        // Branch flush, writeback during flush, re-trigger extension.
        set_issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
        step("w12");
        set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        branch = 1'b1;
        check_cycle("br");
        chk("br/ready_low", issue_ready, 1'b0);
        chk("br/no_stall", stall, 1'b0);
        advance();
        branch = 1'b0;
        set_wb(1'b1, 1'b1, 5'd12);
        check_cycle("fl1");
        chk("fl1/flush", flush, 1'b1);
        chk("fl1/no_stall", stall, 1'b0);
        advance();
        set_wb(1'b0, 1'b0, 5'd0);
        check_cycle("fl2");
        chk("fl2/flush", flush, 1'b1);
        advance();
        check_cycle("fl_end");
        chk("fl_end/flush_low", flush, 1'b0);
        chk("fl_end/ready", issue_ready, 1'b1);
        chk("fl_end/busy_low", busy, 1'b0);
        advance();
        branch = 1'b1;
        step("br2");
        branch = 1'b0;
        step("f1");
        branch = 1'b1;
        check_cycle("br3");
        chk("br3/flush", flush, 1'b1);
        advance();
        branch = 1'b0;
        check_cycle("f2");
        chk("f2/flush", flush, 1'b1);
        advance();
        check_cycle("f3");
        chk("f3/flush", flush, 1'b1);
        advance();
        check_cycle("f4");
        chk("f4/flush_low", flush, 1'b0);
        advance();
        set_idle();

        // x0 is never tracked.
        set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        step("x0a");
        step("x0b");
        set_wb(1'b1, 1'b1, 5'd0);
        check_cycle("x0c");
        chk("x0c/ready", issue_ready, 1'b1);
        chk("x0c/busy_low", busy, 1'b0);
        advance();
        set_idle();

        // Busy execution unit stalls decode.
        set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        exe_busy = 1'b1;
        check_cycle("exe");
        chk("exe/stall", stall, 1'b1);
        advance();
        set_idle();

        // Reset mid-flush with writes in flight.
        set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        step("w3");
        set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        step("w4");
        set_idle();
        branch = 1'b1;
        step("br4");
        branch = 1'b0;
        check_cycle("fl4");
        chk("fl4/flush", flush, 1'b1);
        advance();
        rstn = 1'b0;
        set_issue(1'b1, 5'd3, 5'd0, 5'd3, 1'b1);
        check_cycle("rst_mid");
        chk("rst_mid/flush", flush, 1'b0);
        chk("rst_mid/busy", busy, 1'b0);
        chk("rst_mid/ready", issue_ready, 1'b0);
        chk("rst_mid/stall", stall, 1'b0);
        advance();
        rstn = 1'b1;
        check_cycle("post_rst");
        chk("post_rst/ready", issue_ready, 1'b1);
        chk("post_rst/stall", stall, 1'b0);
        advance();

        // Random traffic; writebacks only target registers with writes in flight.
        for (int k = 0; k < 600; k++) begin
            rstn        = ($urandom_range(99) != 0);
            issue_valid = 1'($urandom_range(1));
            rs1         = 5'($urandom_range(7));
            rs2         = 5'($urandom_range(7));
            rd          = 5'($urandom_range(7));
            issue_we    = 1'($urandom_range(1));
            exe_busy    = ($urandom_range(7) == 0);
            branch      = ($urandom_range(15) == 0);
            q.delete();
            for (int i = 1; i < NR; i++) if (m_cnt[i] > 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(1) == 1) begin
                set_wb(1'b1, 1'b1, 5'(q[$urandom_range(q.size() - 1)]));
            end else begin
                wb_valid = 1'($urandom_range(1));
                wb_we    = 1'($urandom_range(1));
                wb_rd    = (wb_valid && wb_we) ? 5'd0 : 5'($urandom_range(31));
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
